// File: rtl/fetch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_buffer_pkg
// Shared pipeline types for the fetch front-end:
//   - fetch_entry_t : one queued fetch result {pc, instr}
//   - fb_state_t    : instruction-bus request FSM states
//   - RESET_PC      : first fetch address after reset; pc_reg and fetch_buffer
//                     both use it
// No ports (package only).
// -----------------------------------------------------------------------------
package fetch_buffer_pkg;

  localparam int PKG_XLEN = 64;
  localparam int PKG_ILEN = 32;

  localparam logic [PKG_XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FB_IDLE    = 2'd0,
    FB_REQ     = 2'd1,
    FB_DISCARD = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fetch_buffer_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry circular buffer of packed fetch entries. The head entry is read
// straight out of storage, so the consumer sees a registered value.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears storage too)
//   clear        : drop all entries (redirect); has priority over push/pop
//   push, wdata  : append an entry; push while full is only legal with pop
//   pop          : remove the head entry; only issued while not empty
//   head         : current head entry
//   count        : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;

  assign head  = mem[rd_ptr];
  assign count = occ;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Fetch front-end: PC generator, single-outstanding instruction-bus request
// FSM and a DEPTH-entry instruction queue feeding decode. A redirect clears
// the queue and restarts fetch at redirect_pc; a request already on the bus is
// never withdrawn, its response is simply dropped (DISCARD state).
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   ireq_valid, ireq_addr         : ibus request (registered)
//   iresp_addr_ok                 : address accepted (informational only)
//   iresp_data_ok, iresp_data     : returned instruction
//   redirect, redirect_pc         : flush and refetch
//   out_valid/out_ready/out_pc/out_instr : queue head handshake to decode
//   count                         : queue occupancy
// Optional (macro FETCH_BUFFER_PERF_EN):
//   perf_fetched, perf_discarded, perf_full_cycles : 64-bit wrapping counters
// -----------------------------------------------------------------------------
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               XLEN     = 64,
  parameter int               ILEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = fetch_buffer_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ireq_valid,
  output logic [XLEN-1:0]        ireq_addr,
  input  logic                   iresp_addr_ok,
  input  logic                   iresp_data_ok,
  input  logic [ILEN-1:0]        iresp_data,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [ILEN-1:0]        out_instr,
`ifdef FETCH_BUFFER_PERF_EN
  output logic [63:0]            perf_fetched,
  output logic [63:0]            perf_discarded,
  output logic [63:0]            perf_full_cycles,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + ILEN;

  fb_state_t       state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_addr;
  logic            req_valid;

  logic            push;
  logic            pop;
  logic            space_after_push;
  logic [EW-1:0]   head;
  logic [CW-1:0]   occ;
  logic            unused_addr_ok;

  assign unused_addr_ok = iresp_addr_ok;

  // Queue control: redirect (clear) wins over push; pop follows the handshake.
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    space_after_push = 1'b0;
    push = (state == FB_REQ) && iresp_data_ok && !redirect;
    pop  = (occ != '0) && out_ready;
    // count + 1 - pop < DEPTH; with a pop the queue cannot fill.
    space_after_push = pop || (occ < CW'(DEPTH - 1));
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (push),
    .wdata ({fetch_pc, iresp_data}),
    .pop   (pop),
    .head  (head),
    .count (occ)
  );

  assign out_valid  = (occ != '0);
  assign out_pc     = head[ILEN +: XLEN];
  assign out_instr  = head[ILEN-1:0];
  assign count      = occ;
  assign ireq_valid = req_valid;
  assign ireq_addr  = req_addr;

  // Request FSM with PC generator; at most one request outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FB_IDLE;
      fetch_pc  <= RESET_PC;
      req_addr  <= RESET_PC;
      req_valid <= 1'b0;
    end else begin
      case (state)
        FB_IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (occ < CW'(DEPTH)) begin
            state     <= FB_REQ;
            req_addr  <= fetch_pc;
            req_valid <= 1'b1;
          end
        end
        FB_REQ: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            if (iresp_data_ok) begin
              // Response lands with the redirect: drop it, nothing in flight.
              state     <= FB_IDLE;
              req_valid <= 1'b0;
            end else begin
              // Keep the stale request up until its response drains.
              state <= FB_DISCARD;
            end
          end else if (iresp_data_ok) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            if (space_after_push) begin
              req_addr <= fetch_pc + XLEN'(4);
            end else begin
              state     <= FB_IDLE;
              req_valid <= 1'b0;
            end
          end
        end
        FB_DISCARD: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end
          if (iresp_data_ok) begin
            state     <= FB_IDLE;
            req_valid <= 1'b0;
          end
        end
        default: begin
          state     <= FB_IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_BUFFER_PERF_EN
  logic discard_evt;

  assign discard_evt = iresp_data_ok &&
                       ((state == FB_DISCARD) || ((state == FB_REQ) && redirect));

  // Free-running event counters; they wrap silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched     <= 64'd0;
      perf_discarded   <= 64'd0;
      perf_full_cycles <= 64'd0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 64'd1;
      end
      if (discard_evt) begin
        perf_discarded <= perf_discarded + 64'd1;
      end
      if (occ == CW'(DEPTH)) begin
        perf_full_cycles <= perf_full_cycles + 64'd1;
      end
    end
  end
`endif

endmodule
